// File: rtl/regfile_sb.sv
// Parametrised register file (r0 hardwired to zero) with a pending-write scoreboard for RAW hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] Read1,
    output logic [DATA_W-1:0] Read2,
    output logic              Ready1,
    output logic              Ready2,
    input  logic              write,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              issue,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int CW = ADDR_W + 1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;
    logic [CW-1:0]     r_cnt;

    logic              w_wr_en;
    logic              w_iss_en;
    logic [NREGS-1:0]  w_pend_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_byp1;
    logic              w_byp2;

    assign w_wr_en  = write && (WriteReg != '0);
    assign w_iss_en = issue && (IssueReg != '0);

    // Issue is applied after writeback so the newer producer wins; flush squashes both.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_en)
            w_pend_nxt[WriteReg] = 1'b0;
        if (w_iss_en)
            w_pend_nxt[IssueReg] = 1'b1;
        if (flush)
            w_pend_nxt = '0;
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int unsigned i = 1; i < NREGS; i++)
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_en)
                r_regs[WriteReg] <= WriteData;
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign w_rd1 = (ReadReg1 == '0) ? '0 : r_regs[ReadReg1];
    assign w_rd2 = (ReadReg2 == '0) ? '0 : r_regs[ReadReg2];

`ifdef REGFILE_BYPASS_EN
    assign w_byp1 = write && (WriteReg == ReadReg1) && (ReadReg1 != '0);
    assign w_byp2 = write && (WriteReg == ReadReg2) && (ReadReg2 != '0);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign Read1  = w_byp1 ? WriteData : w_rd1;
    assign Read2  = w_byp2 ? WriteData : w_rd2;
    assign Ready1 = (ReadReg1 == '0) || !r_pend[ReadReg1] || w_byp1;
    assign Ready2 = (ReadReg2 == '0) || !r_pend[ReadReg2] || w_byp2;

    assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at DATA_W=16, NREGS=16; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ReadReg1 = '0;
    logic [AW-1:0] ReadReg2 = '0;
    logic [DW-1:0] Read1;
    logic [DW-1:0] Read2;
    logic          Ready1;
    logic          Ready2;
    logic          write = 1'b0;
    logic [AW-1:0] WriteReg = '0;
    logic [DW-1:0] WriteData = '0;
    logic          issue = 1'b0;
    logic [AW-1:0] IssueReg = '0;
    logic          flush = 1'b0;
    logic [AW:0]   pend_cnt;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(.DATA_W(DW), .NREGS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .Read1     (Read1),
        .Read2     (Read2),
        .Ready1    (Ready1),
        .Ready2    (Ready2),
        .write     (write),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .issue     (issue),
        .IssueReg  (IssueReg),
        .flush     (flush),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        // initial reset
        rst = 1'b1;
        tick();
        idle();
        #1;
        chk("rst_cnt", 32'(pend_cnt), 0);
        ReadReg1 = 4'd5; ReadReg2 = 4'd15; #1;
        chk("rst_rd1", 32'(Read1), 0);
        chk("rst_rd2", 32'(Read2), 0);
        chk("rst_rdy1", 32'(Ready1), 1);

        // write r5, visible next cycle
        write = 1'b1; WriteReg = 4'd5; WriteData = 16'hBEEF;
        tick();
        idle();
        #1;
        chk("wr5_rd1", 32'(Read1), 32'hBEEF);
        chk("wr5_rdy1", 32'(Ready1), 1);

        // write r0 is discarded, including in the write cycle
        write = 1'b1; WriteReg = 4'd0; WriteData = 16'h1234;
        ReadReg1 = 4'd0; ReadReg2 = 4'd0; #1;
        chk("wr0_same_rd1", 32'(Read1), 0);
        tick();
        idle();
        #1;
        chk("wr0_rd1", 32'(Read1), 0);
        chk("wr0_rd2", 32'(Read2), 0);
        chk("wr0_rdy1", 32'(Ready1), 1);

        // issue r3 -> pending
        issue = 1'b1; IssueReg = 4'd3;
        tick();
        idle();
        ReadReg1 = 4'd3; #1;
        chk("iss3_rdy1", 32'(Ready1), 0);
        chk("iss3_cnt", 32'(pend_cnt), 1);

        // writeback r3 clears pending
        write = 1'b1; WriteReg = 4'd3; WriteData = 16'h0055;
        tick();
        idle();
        #1;
        chk("wb3_rdy1", 32'(Ready1), 1);
        chk("wb3_rd1", 32'(Read1), 32'h55);
        chk("wb3_cnt", 32'(pend_cnt), 0);

        // bypass: r3 pending, write in same cycle as read on both ports
        issue = 1'b1; IssueReg = 4'd3;
        tick();
        idle();
        write = 1'b1; WriteReg = 4'd3; WriteData = 16'h00A5;
        ReadReg1 = 4'd3; ReadReg2 = 4'd3; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_rd1", 32'(Read1), 32'hA5);
        chk("byp_rd2", 32'(Read2), 32'hA5);
        chk("byp_rdy1", 32'(Ready1), 1);
        chk("byp_rdy2", 32'(Ready2), 1);
`else
        chk("byp_rd1", 32'(Read1), 32'h55);
        chk("byp_rd2", 32'(Read2), 32'h55);
        chk("byp_rdy1", 32'(Ready1), 0);
        chk("byp_rdy2", 32'(Ready2), 0);
`endif
        tick();
        idle();
        #1;
        chk("byp_after_rd1", 32'(Read1), 32'hA5);
        chk("byp_after_rdy2", 32'(Ready2), 1);
        chk("byp_after_cnt", 32'(pend_cnt), 0);

        // issue + write same register: data stored, still pending
        issue = 1'b1; IssueReg = 4'd4;
        write = 1'b1; WriteReg = 4'd4; WriteData = 16'h1111;
        tick();
        idle();
        ReadReg1 = 4'd4; #1;
        chk("iw4_rd1", 32'(Read1), 32'h1111);
        chk("iw4_rdy1", 32'(Ready1), 0);
        chk("iw4_cnt", 32'(pend_cnt), 1);

        // flush squashes issue r6 and clears r4; write r7 still lands
        issue = 1'b1; IssueReg = 4'd6; flush = 1'b1;
        write = 1'b1; WriteReg = 4'd7; WriteData = 16'h7777;
        tick();
        idle();
        ReadReg1 = 4'd6; ReadReg2 = 4'd4; #1;
        chk("fl_rdy6", 32'(Ready1), 1);
        chk("fl_rdy4", 32'(Ready2), 1);
        chk("fl_cnt", 32'(pend_cnt), 0);
        ReadReg1 = 4'd7; #1;
        chk("fl_wr7", 32'(Read1), 32'h7777);

        // issue to r0 sets nothing
        issue = 1'b1; IssueReg = 4'd0;
        tick();
        idle();
        ReadReg1 = 4'd0; #1;
        chk("iss0_cnt", 32'(pend_cnt), 0);
        chk("iss0_rdy", 32'(Ready1), 1);

        // repeated issue does not double count
        issue = 1'b1; IssueReg = 4'd9;
        tick();
        tick();
        IssueReg = 4'd10;
        tick();
        idle();
        #1;
        chk("dbl_cnt", 32'(pend_cnt), 2);

        // reset mid-operation
        write = 1'b1; WriteReg = 4'd1; WriteData = 16'h0101;
        tick();
        idle();
        issue = 1'b1; IssueReg = 4'd1; tick();
        IssueReg = 4'd2; tick();
        IssueReg = 4'd7; tick();
        idle();
        #1;
        chk("pre_rst_cnt", 32'(pend_cnt), 5);
        ReadReg1 = 4'd1; #1;
        chk("pre_rst_rd1", 32'(Read1), 32'h0101);
        rst = 1'b1;
        write = 1'b1; WriteReg = 4'd1; WriteData = 16'hFFFF;
        issue = 1'b1; IssueReg = 4'd2;
        tick();
        idle();
        #1;
        chk("mrst_cnt", 32'(pend_cnt), 0);
        for (int a = 0; a < NR; a++) begin
            ReadReg1 = AW'(a);
            ReadReg2 = AW'(NR - 1 - a);
            #1;
            chk($sformatf("mrst_rd1_r%0d", a), 32'(Read1), 0);
            chk($sformatf("mrst_rd2_r%0d", NR - 1 - a), 32'(Read2), 0);
            chk($sformatf("mrst_rdy1_r%0d", a), 32'(Ready1), 1);
            chk($sformatf("mrst_rdy2_r%0d", NR - 1 - a), 32'(Ready2), 1);
        end

        // count saturates at NREGS-1 with every register pending
        for (int r = 1; r < NR; r++) begin
            issue = 1'b1; IssueReg = AW'(r);
            tick();
        end
        idle();
        #1;
        chk("full_cnt", 32'(pend_cnt), NR - 1);
        ReadReg1 = 4'd15; ReadReg2 = 4'd0; #1;
        chk("full_rdy15", 32'(Ready1), 0);
        chk("full_rdy0", 32'(Ready2), 1);
        flush = 1'b1;
        tick();
        idle();
        #1;
        chk("full_flush_cnt", 32'(pend_cnt), 0);
        chk("full_flush_rdy15", 32'(Ready1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x8 pipeline register file.
- Generalises data width and register count, and keeps register 0 hardwired to zero.
- Adds synchronous reset and a per-register pending-write scoreboard.
- The ID stage uses the scoreboard to detect RAW hazards. Issue marks a destination register pending; writeback clears it. Each read port reports whether its operand is ready.

Parameters:
DATA_W, 8, register data width in bits
NREGS, 8, number of registers; must be a power of two, at least 2
ADDR_W, $clog2(NREGS), register address width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
ReadReg1  in  ADDR_W  read port 1 address
ReadReg2  in  ADDR_W  read port 2 address
Read1  out  DATA_W  read port 1 data, combinational
Read2  out  DATA_W  read port 2 data, combinational
Ready1  out  1  port 1 operand is not pending (or is bypassed)
Ready2  out  1  port 2 operand is not pending (or is bypassed)
write  in  1  writeback enable
WriteReg  in  ADDR_W  writeback destination
WriteData  in  DATA_W  writeback data
issue  in  1  an instruction is issued that will write IssueReg
IssueReg  in  ADDR_W  destination of the issued instruction
flush  in  1  clear all pending bits (pipeline squash)
pend_cnt  out  ADDR_W+1  number of registers currently pending, registered

Behaviour:
- Reset (rst=1 at a posedge):
  - all registers and all pending bits go to 0; pend_cnt=0.
  - rst overrides write, issue and flush in that cycle.
  - Read1/Read2 therefore return 0; Ready1/Ready2 return 1.
- Register 0:
  - always reads 0 and is never pending.
  - A write to 0 is discarded; an issue to 0 sets no pending bit.
- Write: at posedge with write=1 and WriteReg!=0, Registers[WriteReg] <= WriteData and pending[WriteReg] <= 0.
- Issue: at posedge with issue=1 and IssueReg!=0, pending[IssueReg] <= 1.
- Issue and write in the same cycle to the same register:
  - data is written and pending ends up 1, because the newer producer wins.
  - A same-cycle read of that register gets the bypassed WriteData with Ready=1, since the issue takes effect next cycle.
- Issue to a register that is already pending: pending stays 1 (no counting per register).
- Flush: at posedge with flush=1, all pending bits go to 0 after the write/issue updates.
  - A simultaneous issue is squashed; its pending bit ends at 0.
  - A simultaneous write still updates register data.
- Reads:
  - Read1 = bypass hit ? WriteData : Registers[ReadReg1]; Read2 likewise.
  - Bypass hit = write && WriteReg==ReadRegN && ReadRegN!=0 (bypass built in; see Optional Feature).
  - ReadyN = (ReadRegN==0) || !pending[ReadRegN] || bypass hit.
  - Reads are combinational with zero latency. Written data is visible through storage from the cycle after the write edge.
- pend_cnt:
  - registered population count of the pending bits; updated in the same edge as the bits.
  - Range 0..NREGS-1.
- Undriven or X addresses are not supported; the bench must drive all inputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-through forwarding on both read ports as described, and ReadyN includes the bypass hit.
- Undefined:
  - no forwarding; ReadN = Registers[ReadRegN] only.
  - ReadyN = (ReadRegN==0) || !pending[ReadRegN].
  - A read in the write cycle returns the old value with Ready=0 if the register was pending.

Test Plan:
- Reset: after any activity, rst=1 for 1 cycle -> Read1=Read2=0 for all addresses, Ready1=Ready2=1, pend_cnt=0.
- Write/read with NREGS=16, DATA_W=16:
  - write r5=0xBEEF, read r5 on the next cycle -> Read1=0xBEEF.
  - write r0=0x1234 -> r0 reads 0, Ready=1.
- Scoreboard:
  - issue r3 -> next cycle Ready1=0 for r3 and pend_cnt=1.
  - write r3=0x55 -> Ready1=1, Read1=0x55, pend_cnt=0.
- Bypass:
  - with r3 pending, write r3=0xA5 while reading r3 on both ports in the same cycle.
  - Defined: Read1=Read2=0xA5, Ready=1.
  - Undefined: old value, Ready=0.
- Simultaneous events:
  - issue+write same r4 -> data stored, pending=1, pend_cnt increments.
  - issue r6 with flush -> pending r6=0, pend_cnt=0.
- Reset mid-operation:
  - r1, r2 and r7 pending, then rst together with write r1 and issue r2 -> all pending 0, r1 reads 0, pend_cnt=0.
